// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product datapath.
// Result width and frame length of the 6-byte dot-product stage.
package dot_pkg;

    localparam int DOT_W     = 18;
    localparam int FRAME_LEN = 6;

    typedef logic [DOT_W-1:0] dot_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extended pointers and registered occupancy.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
    parameter  int DW    = 18,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          push;
    logic          pop;

    // Extra pointer MSB separates full from empty.
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dot_result_fifo.sv
// Buffers dot-product results, skipping the post-reset dummy result.
// Overflow drops are counted since the producer cannot be stalled.
module dot_result_fifo
    import dot_pkg::*;
#(
    parameter int DW    = DOT_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   run_in,
    input  logic [DW-1:0]          res_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DW-1:0]          m_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt,
    input  logic                   clr_stat
);

    logic             armed_q, armed_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             push_req;
    logic             full;
    logic             empty;
    logic             drop;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push_req),
        .wr_data (res_in),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign m_valid  = !empty;
    assign push_req = run_in && armed_q;
    assign drop     = push_req && full && !(m_valid && m_ready);

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        armed_d    = armed_q || run_in;
        overflow_d = overflow_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        // Clear takes priority over a coincident drop.
        if (clr_stat) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            armed_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            armed_q    <= armed_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_dot_result_fifo.sv
// Directed scoreboard bench for dot_result_fifo.
module tb_dot_result_fifo;

    localparam int DW    = 18;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          run_in = 1'b0;
    logic [DW-1:0] res_in = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [2:0]    level;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          clr_stat = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb[$];
    bit            m_armed;
    bit            m_ovf;
    int            m_cnt;

    dot_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .run_in   (run_in),
        .res_in   (res_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_stat (clr_stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
        chk("level", 32'(level), 32'(sb.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    endtask

    // One clock: drive inputs, score any pop, update model, check stats.
    task automatic step(input logic run, input logic [DW-1:0] res,
                        input logic rdy, input logic clr);
        bit full_m, pop_m, preq;
        run_in   = run;
        res_in   = res;
        m_ready  = rdy;
        clr_stat = clr;
        #1;
        chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
        full_m = sb.size() == DEPTH;
        pop_m  = (sb.size() != 0) && rdy;
        preq   = run && m_armed;
        if (pop_m) begin
            chk("m_data", 32'(m_data), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (preq && (!full_m || pop_m)) sb.push_back(res);
        else if (preq) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (run) m_armed = 1'b1;
        @(posedge clk);
        #1;
        chk_stats();
    endtask

    task automatic frame(input logic [DW-1:0] res, input logic rdy);
        step(1'b1, res, rdy, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        run_in  = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb.delete();
        m_armed = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk_stats();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Dummy skip
        frame(18'd0, 1'b0);
        chk("dummy_level", 32'(level), 32'd0);
        frame(18'd32, 1'b0);
        chk("first_level", 32'(level), 32'd1);
        chk("first_data", 32'(m_data), 32'd32);

        // In-order streaming
        frame(18'd32, 1'b1);
        frame(18'h3FFFF, 1'b1);
        frame(18'd7, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_ovf", 32'(overflow), 32'd0);
        chk("stream_empty", 32'(level), 32'd0);

        // Full and drop
        for (int i = 1; i <= 6; i++) frame(DW'(i * 3 + 100), 1'b0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_drops", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drained", 32'(m_valid), 32'd0);

        // Push and pop while full
        for (int i = 0; i < 4; i++) frame(DW'(i + 10), 1'b0);
        step(1'b1, 18'h2A5A5, 1'b1, 1'b0);
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_drops", 32'(drop_cnt), 32'd2);

        // Saturation and clear
        for (int i = 0; i < 300; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        chk("sat_cnt", 32'(drop_cnt), 32'd255);
        step(1'b1, 18'd5, 1'b0, 1'b1);
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Mid-stream reset
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd3);
        do_reset();
        frame(18'h155, 1'b0);
        chk("rearm_skip", 32'(level), 32'd0);
        frame(18'h2AAAA, 1'b0);
        chk("rearm_level", 32'(level), 32'd1);
        chk("rearm_data", 32'(m_data), 32'h2AAAA);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("final_level", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_result_fifo.md
# dot_result_fifo

Collects the 18-bit dot-product results that the 6-byte dot-product stage produces once per frame and hands them to downstream logic over a valid/ready stream. It sits directly downstream of the dot-product stage. It qualifies that stage's `run` strobe, drops the dummy zero result produced right after reset, and buffers results in a small FIFO. Overflow is counted rather than stalling, because the upstream stage cannot be back-pressured.

## Interface

- `DW`, 18: result width; must match the dot-product stage output.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the drop counter.

- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `run_in`  in  1  result strobe from the dot-product stage; high one cycle in six.
- `res_in`  in  DW  dot-product result; valid only while `run_in`=1.
- `m_valid`  out  1  head entry available.
- `m_ready`  in  1  consumer accepts the head entry.
- `m_data`  out  DW  head entry; defined only while `m_valid`=1.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one result has been dropped.
- `drop_cnt`  out  CNT_W  number of dropped results; saturates at all-ones.
- `clr_stat`  in  1  synchronous clear of `overflow` and `drop_cnt`.

## Operation

- **Arming.**
  - The `armed` flag is 0 after reset.
  - The first `run_in` pulse after reset only sets `armed`. That pulse carries the all-zero dummy result and is never pushed.
  - Every later `run_in` pulse is a push request.
- **Push.**
  - Condition: `run_in`=1, `armed`=1, and either not full, or full with a pop in the same cycle.
  - Action: `res_in` is written at `wr_ptr`, then `wr_ptr` advances.
- **Pop.** Condition: `m_valid`=1 and `m_ready`=1. Action: `rd_ptr` advances.
- **Full drop.**
  - Condition: a push request while full and no pop in that cycle.
  - Action: the result is discarded, `overflow` is set to 1, and `drop_cnt` increments (saturating).
- **Simultaneous push and pop.**
  - Both happen and `level` is unchanged.
  - This also applies when full, so no drop occurs in that case.
- **Pointers.** Width is $clog2(DEPTH)+1, and the extra MSB distinguishes full from empty.
  - Empty: pointers are equal.
  - Full: MSBs differ and the low bits are equal.
  - Wrap-around is natural binary roll-over.
- **Statistics clear.** `clr_stat`=1 zeroes `overflow` and `drop_cnt`. If a drop happens in the same cycle, the clear wins.
- **Reset, including mid-stream:**
  - Pointers, `level`, `armed`, `overflow` and `drop_cnt` all go to 0.
  - FIFO contents are discarded.
  - `m_valid`=0 in the cycle after reset is sampled low.
  - Re-arming is required, because the upstream stage restarts its frame on the same reset.
- **Data integrity.** No arithmetic is done on the data; results pass through bit-exact.

## Timing

- Reset values: `m_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0. `m_data` is don't-care.
- Push-to-visible latency is 1 cycle: a result accepted at edge N gives `m_valid`=1 and `m_data`=result after edge N.
- `m_data` is read combinationally from storage at `rd_ptr`. It stays stable while `m_valid`=1 and `m_ready`=0.
- `m_valid` must not depend combinationally on `m_ready`.
- `level`, `overflow` and `drop_cnt` are registered and update at the same edge as the push, pop or drop that changes them.
- `m_ready` may be held high constantly. With `DEPTH`≥2 and one result every 6 cycles, no drops occur in that case.

## Structure

- Shared package `dot_pkg` holds:
  - `DOT_W`=18;
  - `FRAME_LEN`=6;
  - typedef `dot_res_t` = logic [DOT_W-1:0].
- Sub-module `sync_fifo` (parameters `DW`, `DEPTH`) implements storage, pointers, full/empty, `level`, and the push/pop rules.
- The top level adds arming, drop detection and statistics.

## Test plan

- **Dummy skip.** Reset, then `run_in` pulse with `res_in`=0, then a pulse with 32 (bytes 1..6: 1·4+2·5+3·6) → exactly one entry, `m_data`=32, `level`=1.
- **In-order streaming.** `m_ready`=1; results 32, 0x3FFFF, 7 at 6-cycle spacing → all three emerged in order, each 1 cycle after its pulse; `overflow`=0.
- **Full and drop.** `m_ready`=0, DEPTH=4; 6 armed pulses → `level`=4, `overflow`=1, `drop_cnt`=2; draining yields the first 4 values only.
- **Push and pop while full.** Full; `run_in` pulse and pop in the same cycle → `level` stays 4, new value lands at tail, `drop_cnt` unchanged.
- **Saturation and clear.** Force 300 drops → `drop_cnt`=255; `clr_stat` coincident with another drop → `drop_cnt`=0 and `overflow`=0 next cycle.
- **Mid-stream reset.** `level`=3, assert `resetn`=0 for 1 cycle → `m_valid`=0 and `level`=0; the next pulse is skipped as dummy; the following pulse is stored.
